timer_counter: RTL

Memory-mapped 32-bit down-counting timer that generates hardware interrupt requests for the coprocessor-0 exception unit. It sits on the processor's peripheral bus, behind the address decoder. Its `irq` output drives one bit of the `HWInt[5:0]` vector that CP0 samples every cycle, masks with SR.IM, and converts into an interrupt request. Software programs it via word stores and reads it via word loads.

---
 rtl/timer_counter.sv | 111 +++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes.
// Drives a level interrupt request into one bit of the CP0 HWInt vector.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'b01;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic        w_en;
  logic        w_auto_reload;
  logic        w_im;

  assign w_en          = r_ctrl[0];
  assign w_auto_reload = (r_ctrl[2:1] == MODE_AUTO);
  assign w_im          = r_ctrl[3];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge register values regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_en) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_count    <= r_preset;
          r_irq_flag <= 1'b0;
          r_state    <= S_CNT;
        end
        S_CNT: begin
          if (!w_en) begin
            r_state <= S_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            // A count of 0 or 1 terminates, so PRESET = 0 acts like 1.
            r_count    <= 32'd0;
            r_irq_flag <= 1'b1;
            r_state    <= S_INT;
          end
        end
        S_INT: begin
          if (w_auto_reload) begin
            r_irq_flag <= 1'b0;
            r_state    <= S_LOAD;
          end else begin
            r_ctrl[0] <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // NOTE: the bus write is placed after the FSM so that, when both touch
      // CTRL or irq_flag on the same edge, the last non-blocking write (the
      // software value) is the one that lands.
      if (we) begin
        unique case (addr)
          ADDR_CTRL: begin
            r_ctrl     <= din[3:0];
            r_irq_flag <= 1'b0;
          end
          ADDR_PRESET: r_preset <= din;
          default: ;
        endcase
      end
    end
  end

  // NOTE: every path assigns dout, so no latch is inferred.
  always_comb begin
    dout = 32'd0;
    unique case (addr)
      ADDR_CTRL:   dout = {28'd0, r_ctrl};
      ADDR_PRESET: dout = r_preset;
      ADDR_COUNT:  dout = r_count;
      default:     dout = 32'd0;
    endcase
  end

  assign irq = r_irq_flag & w_im;

endmodule
